// File: rtl/my_pkg.sv
// Shared mesh-wide constants for the node-to-node link.
package my_pkg;
    parameter int PACKET_LENGTH = 16;
endpackage

// File: rtl/edge_sink_node_if.sv
// Host/collector side of the edge sink: show-ahead FIFO head with a valid/ready pop.
interface edge_sink_node_if;
    // Handshake: the head is consumed in any cycle where pkt_valid && pkt_ready are both high;
    // pkt_valid never depends on pkt_ready, and pkt_ready while pkt_valid is low is ignored.
    logic signed [my_pkg::PACKET_LENGTH-1:0] pkt_out;
    logic [1:0]                              pkt_src;
    logic                                    pkt_valid;
    logic                                    pkt_ready;

    modport master (output pkt_out, output pkt_src, output pkt_valid, input pkt_ready);
    modport slave  (input pkt_out, input pkt_src, input pkt_valid, output pkt_ready);
endinterface

// File: rtl/edge_sink_node.sv
// Mesh boundary sink: reads packets from up to four neighbours round-robin and queues
// them, tagged with their source side, for a host collector.
module edge_sink_node
    import my_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic signed [PACKET_LENGTH-1:0] n_in,
    input  logic signed [PACKET_LENGTH-1:0] e_in,
    input  logic signed [PACKET_LENGTH-1:0] s_in,
    input  logic signed [PACKET_LENGTH-1:0] w_in,
    input  logic                            n_valid_in,
    input  logic                            e_valid_in,
    input  logic                            s_valid_in,
    input  logic                            w_valid_in,
    output logic                            is_reading_n,
    output logic                            is_reading_e,
    output logic                            is_reading_s,
    output logic                            is_reading_w,
    edge_sink_node_if.master                host,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [15:0]                     pkt_total
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PACKET_LENGTH + 2;

    logic [3:0]                     side_valid;
    logic [PACKET_LENGTH-1:0]       side_data [4];
    logic [1:0]                     rr_ptr;
    logic [1:0]                     grant;
    logic                           grant_valid;
    logic                           full;
    logic                           push;
    logic                           pop;
    logic [AW-1:0]                  wr_ptr;
    logic [AW-1:0]                  rd_ptr;
    logic [EW-1:0]                  mem [FIFO_DEPTH];
    logic [EW-1:0]                  head;

    // Side index order is N=0, E=1, S=2, W=3 everywhere, including the stored tag.
    assign side_valid   = {w_valid_in, s_valid_in, e_valid_in, n_valid_in};
    assign side_data[0] = n_in;
    assign side_data[1] = e_in;
    assign side_data[2] = s_in;
    assign side_data[3] = w_in;

    always_comb begin
        grant       = rr_ptr;
        grant_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!grant_valid && side_valid[rr_ptr + 2'(i)]) begin
                grant       = rr_ptr + 2'(i);
                grant_valid = 1'b1;
            end
        end
    end

    // Full blocks acceptance even if the host pops this cycle; rst_n gating keeps
    // the read strobes low for the whole reset window, not just after a clock edge.
    assign full = (fifo_count == CW'(FIFO_DEPTH));
    assign push = rst_n && grant_valid && !full;
    assign pop  = host.pkt_valid && host.pkt_ready;

    assign is_reading_n = push && (grant == 2'd0);
    assign is_reading_e = push && (grant == 2'd1);
    assign is_reading_s = push && (grant == 2'd2);
    assign is_reading_w = push && (grant == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= 2'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            pkt_total  <= 16'd0;
        end else begin
            if (push) begin
                rr_ptr    <= grant + 2'd1;
                wr_ptr    <= wr_ptr + AW'(1);
                pkt_total <= pkt_total + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    // Storage is not reset; the occupancy count alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {grant, side_data[grant]};
        end
    end

    assign head           = mem[rd_ptr];
    assign host.pkt_valid = (fifo_count != '0);
    assign host.pkt_out   = host.pkt_valid ? $signed(head[PACKET_LENGTH-1:0]) : '0;
    assign host.pkt_src   = host.pkt_valid ? head[EW-1:PACKET_LENGTH] : 2'd0;

endmodule

// File: tb/tb_edge_sink_node.sv
// Bench for edge_sink_node: vector table, hand-written corner sequences, and a
// queue-based reference model under random neighbour and host traffic.
module tb_edge_sink_node;
    import my_pkg::*;

    localparam int PL    = PACKET_LENGTH;
    localparam int DEPTH = 8;
    localparam int EW    = PL + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [3:0]            drv_valid = 4'b0;
    logic [PL-1:0]         drv_data [4];
    logic signed [PL-1:0]  n_in, e_in, s_in, w_in;
    logic                  n_valid_in, e_valid_in, s_valid_in, w_valid_in;
    logic                  is_reading_n, is_reading_e, is_reading_s, is_reading_w;
    logic [3:0]            fifo_count;
    logic [15:0]           pkt_total;
    logic [3:0]            rd_vec;
    logic [PL-1:0]         out_u;

    edge_sink_node_if host_if ();

    edge_sink_node #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .n_in         (n_in),
        .e_in         (e_in),
        .s_in         (s_in),
        .w_in         (w_in),
        .n_valid_in   (n_valid_in),
        .e_valid_in   (e_valid_in),
        .s_valid_in   (s_valid_in),
        .w_valid_in   (w_valid_in),
        .is_reading_n (is_reading_n),
        .is_reading_e (is_reading_e),
        .is_reading_s (is_reading_s),
        .is_reading_w (is_reading_w),
        .host         (host_if),
        .fifo_count   (fifo_count),
        .pkt_total    (pkt_total)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    assign n_in       = $signed(drv_data[0]);
    assign e_in       = $signed(drv_data[1]);
    assign s_in       = $signed(drv_data[2]);
    assign w_in       = $signed(drv_data[3]);
    assign n_valid_in = drv_valid[0];
    assign e_valid_in = drv_valid[1];
    assign s_valid_in = drv_valid[2];
    assign w_valid_in = drv_valid[3];
    assign rd_vec     = {is_reading_w, is_reading_s, is_reading_e, is_reading_n};
    assign out_u      = host_if.pkt_out;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string nm, input logic [3:0] rd, input logic pv,
                                 input logic [PL-1:0] o, input logic [1:0] src,
                                 input logic [3:0] cnt, input logic [15:0] tot);
        check($sformatf("%s.is_reading", nm), rd_vec, rd);
        check($sformatf("%s.pkt_valid", nm), host_if.pkt_valid, pv);
        check($sformatf("%s.pkt_out", nm), out_u, o);
        check($sformatf("%s.pkt_src", nm), host_if.pkt_src, src);
        check($sformatf("%s.fifo_count", nm), fifo_count, cnt);
        check($sformatf("%s.pkt_total", nm), pkt_total, tot);
    endtask

    // Returns at a falling edge with rst_n just released.
    task automatic apply_reset();
        rst_n = 1'b0;
        drv_valid = 4'b0;
        host_if.pkt_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [EW-1:0] exp_q[$];
    int m_rr;
    int m_total;
    int m_accepted;

    task automatic model_reset();
        exp_q.delete();
        m_rr = 0;
        m_total = 0;
        m_accepted = 0;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic model_step(input int p_valid, input int p_ready);
        int best;
        logic [3:0] exp_rd;
        logic [EW-1:0] hd;
        logic exp_pv;
        bit do_pop;
        #1;
        best = -1;
        for (int k = 0; k < 4; k++) begin
            int s;
            s = (m_rr + k) % 4;
            if (best < 0 && drv_valid[s]) best = s;
        end
        if (exp_q.size() == DEPTH) best = -1;
        exp_rd = (best >= 0) ? 4'(1 << best) : 4'b0;
        exp_pv = (exp_q.size() != 0);
        hd = exp_pv ? exp_q[0] : '0;
        check_outputs("model", exp_rd, exp_pv, hd[PL-1:0], hd[EW-1:PL],
                      4'(exp_q.size()), 16'(m_total));
        do_pop = exp_pv && host_if.pkt_ready;
        @(posedge clk);
        if (do_pop) void'(exp_q.pop_front());
        if (best >= 0) begin
            exp_q.push_back({2'(best), drv_data[best]});
            m_rr = (best + 1) % 4;
            m_total = (m_total + 1) % 65536;
            m_accepted++;
        end
        @(negedge clk);
        // A neighbour only changes its offer after it has been read.
        for (int s = 0; s < 4; s++) begin
            if (!drv_valid[s] || exp_rd[s]) begin
                drv_valid[s] = ($urandom_range(0, 99) < p_valid);
                drv_data[s]  = PL'($urandom);
            end
        end
        host_if.pkt_ready = ($urandom_range(0, 99) < p_ready);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]    valid;
        logic          ready;
        logic [PL-1:0] nd;
        logic [3:0]    rd;
        logic          pv;
        logic [PL-1:0] o;
        logic [1:0]    src;
        logic [3:0]    cnt;
        logic [15:0]   tot;
    } vec_t;

    vec_t vecs[9];

    initial begin
        host_if.pkt_ready = 1'b0;
        for (int s = 0; s < 4; s++) drv_data[s] = '0;

        vecs[0] = '{4'b0001, 1'b0, 'h15, 4'b0001, 1'b0, 'h0,  2'd0, 4'd0, 16'd0};
        vecs[1] = '{4'b0000, 1'b1, 'h15, 4'b0000, 1'b1, 'h15, 2'd0, 4'd1, 16'd1};
        vecs[2] = '{4'b1111, 1'b1, 'h1,  4'b0010, 1'b0, 'h0,  2'd0, 4'd0, 16'd1};
        vecs[3] = '{4'b1111, 1'b1, 'h1,  4'b0100, 1'b1, 'h2,  2'd1, 4'd1, 16'd2};
        vecs[4] = '{4'b1111, 1'b1, 'h1,  4'b1000, 1'b1, 'h3,  2'd2, 4'd1, 16'd3};
        vecs[5] = '{4'b1111, 1'b1, 'h1,  4'b0001, 1'b1, 'h4,  2'd3, 4'd1, 16'd4};
        vecs[6] = '{4'b1111, 1'b1, 'h1,  4'b0010, 1'b1, 'h1,  2'd0, 4'd1, 16'd5};
        vecs[7] = '{4'b0000, 1'b1, 'h1,  4'b0000, 1'b1, 'h2,  2'd1, 4'd1, 16'd6};
        vecs[8] = '{4'b0000, 1'b0, 'h1,  4'b0000, 1'b0, 'h0,  2'd0, 4'd0, 16'd6};

        // Reset state, sampled while rst_n is still low.
        @(negedge clk);
        #1;
        check_outputs("reset", 4'b0, 1'b0, '0, 2'd0, 4'd0, 16'd0);

        apply_reset();
        drv_data[1] = 'h2;
        drv_data[2] = 'h3;
        drv_data[3] = 'h4;
        for (int i = 0; i < 9; i++) begin
            drv_valid = vecs[i].valid;
            host_if.pkt_ready = vecs[i].ready;
            drv_data[0] = vecs[i].nd;
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].rd, vecs[i].pv, vecs[i].o,
                          vecs[i].src, vecs[i].cnt, vecs[i].tot);
            cycle();
        end

        // Fill to full with host stalled, then a one-cycle pop must not admit a packet.
        apply_reset();
        drv_valid = 4'b0010;
        for (int k = 0; k < DEPTH; k++) begin
            drv_data[1] = PL'(100 + k);
            #1;
            check($sformatf("fill%0d.is_reading", k), rd_vec, 4'b0010);
            cycle();
        end
        drv_data[1] = PL'(108);
        #1;
        check_outputs("full", 4'b0000, 1'b1, PL'(100), 2'd1, 4'd8, 16'd8);
        host_if.pkt_ready = 1'b1;
        #1;
        check("full_pop.is_reading", rd_vec, 4'b0000);
        cycle();
        host_if.pkt_ready = 1'b0;
        #1;
        check_outputs("after_pop", 4'b0010, 1'b1, PL'(101), 2'd1, 4'd7, 16'd8);
        cycle();
        #1;
        check_outputs("refull", 4'b0000, 1'b1, PL'(101), 2'd1, 4'd8, 16'd9);

        // Simultaneous push and pop at count 3.
        apply_reset();
        drv_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            drv_data[0] = PL'(10 + k);
            cycle();
        end
        drv_data[0] = PL'(13);
        host_if.pkt_ready = 1'b1;
        #1;
        check_outputs("pushpop_pre", 4'b0001, 1'b1, PL'(10), 2'd0, 4'd3, 16'd3);
        cycle();
        #1;
        check_outputs("pushpop_post", 4'b0001, 1'b1, PL'(11), 2'd0, 4'd3, 16'd4);

        // Asynchronous reset in the middle of traffic with five packets buffered.
        host_if.pkt_ready = 1'b0;
        drv_data[0] = PL'(14);
        cycle();
        drv_data[0] = PL'(15);
        cycle();
        #1;
        check("pre_reset.fifo_count", fifo_count, 4'd5);
        drv_valid = 4'b1111;
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs("async_reset", 4'b0000, 1'b0, '0, 2'd0, 4'd0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset.first_grant", rd_vec, 4'b0001);
        cycle();
        #1;
        check_outputs("post_reset", 4'b0010, 1'b1, PL'(15), 2'd0, 4'd1, 16'd1);

        // Random traffic against the reference model.
        apply_reset();
        model_reset();
        for (int c = 0; c < 3000 && errors <= 50; c++) model_step(60, 50);

        // Long run past the 16-bit counter wrap, data checked across pointer wrap.
        apply_reset();
        model_reset();
        drv_valid = 4'b1111;
        for (int s = 0; s < 4; s++) drv_data[s] = PL'($urandom);
        host_if.pkt_ready = 1'b1;
        for (int c = 0; c < 72000 && m_accepted < 65537 && errors <= 50; c++) model_step(100, 98);
        if (m_accepted < 65537) begin
            checks++;
            errors++;
            $display("FAIL wrap_budget: accepted %0d required 65537", m_accepted);
        end else begin
            #1;
            check("wrap.pkt_total", pkt_total, 16'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
